// File: rtl/btn_event_gen.sv
// btn_event_gen: turns debounced button/switch levels into single-cycle
// press, release and auto-repeat pulses per button, a held level per button,
// a registered switch copy and per-bit switch-change pulses.
// Each button runs its own IDLE/ARMED/REPEAT machine with a private counter.
// The packed fsm_state vector carries all four state codes so checkers can
// bind to it without reaching into the per-button arrays.
module btn_event_gen #(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] button_in,
  input  logic [7:0] sw_in,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic [3:0] btn_repeat,
  output logic [3:0] btn_held,
  output logic [7:0] sw_state,
  output logic [7:0] sw_change
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Terminal counter values: the counter is cleared when it reaches these,
  // so it never needs to wrap.
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Per-button state and counters, packed so one vector holds all four.
  logic [3:0][1:0]       state;
  logic [3:0][CNT_W-1:0] cnt;

  logic [3:0][1:0]       state_nxt;
  logic [3:0][CNT_W-1:0] cnt_nxt;
  logic [3:0]            press_nxt;
  logic [3:0]            release_nxt;
  logic [3:0]            repeat_nxt;
  logic [3:0]            held_nxt;

  // Debug view of all four machines, bit pair [2i+1:2i] is button i.
  logic [7:0] fsm_state;
  assign fsm_state = state;

  // Next-state and pulse decode for each button; release wins over repeat.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = '0;
    release_nxt = '0;
    repeat_nxt  = '0;
    held_nxt    = '0;
    for (int i = 0; i < 4; i++) begin
      case (state[i])
        ST_IDLE: begin
          if (button_in[i]) begin
            state_nxt[i] = ST_ARMED;
            press_nxt[i] = 1'b1;
            cnt_nxt[i]   = '0;
          end
        end
        ST_ARMED: begin
          if (!button_in[i]) begin
            state_nxt[i]   = ST_IDLE;
            release_nxt[i] = 1'b1;
            cnt_nxt[i]     = '0;
          end else if (cnt[i] == HOLD_LAST) begin
            state_nxt[i]  = ST_REPEAT;
            repeat_nxt[i] = 1'b1;
            held_nxt[i]   = 1'b1;
            cnt_nxt[i]    = '0;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (!button_in[i]) begin
            state_nxt[i]   = ST_IDLE;
            release_nxt[i] = 1'b1;
            cnt_nxt[i]     = '0;
          end else begin
            held_nxt[i] = 1'b1;
            if (cnt[i] == REPEAT_LAST) begin
              repeat_nxt[i] = 1'b1;
              cnt_nxt[i]    = '0;
            end else begin
              cnt_nxt[i] = cnt[i] + CNT_ONE;
            end
          end
        end
        default: begin
          state_nxt[i] = ST_IDLE;
          cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  // Button machines, counters and all button outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= {4{ST_IDLE}};
      cnt         <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_repeat  <= '0;
      btn_held    <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
      btn_repeat  <= repeat_nxt;
      btn_held    <= held_nxt;
    end
  end

  // Switch copy and toggle detection against the previously registered copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_state  <= '0;
      sw_change <= '0;
    end else begin
      sw_state  <= sw_in;
      sw_change <= sw_in ^ sw_state;
    end
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Bench for btn_event_gen with HOLD_CYCLES=8, REPEAT_CYCLES=4.
// The reference model tracks, per button, whether it is down and how many
// edges it has been held; pulses follow from that age by arithmetic.
module tb_btn_event_gen;

  localparam int HOLD = 8;
  localparam int REP  = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] button_in = '0;
  logic [7:0] sw_in = '0;

  logic [3:0] btn_press, btn_release, btn_repeat, btn_held;
  logic [7:0] sw_state, sw_change;

  always #5 clk = ~clk;

  btn_event_gen #(
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button_in  (button_in),
    .sw_in      (sw_in),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat),
    .btn_held   (btn_held),
    .sw_state   (sw_state),
    .sw_change  (sw_change)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected word: {press, release, repeat, held, sw_state, sw_change}
  logic [31:0] exp_q[$];
  bit          m_down[4];
  int          m_age[4];
  logic [7:0]  m_sw;

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] p, r, t, h;
    logic [7:0] c;
    if (!rst_n) begin
      exp_q.delete();
      m_sw = '0;
      for (int i = 0; i < 4; i++) begin
        m_down[i] = 1'b0;
        m_age[i]  = 0;
      end
    end else begin
      p = '0; r = '0; t = '0; h = '0;
      for (int i = 0; i < 4; i++) begin
        if (!m_down[i]) begin
          if (button_in[i]) begin
            m_down[i] = 1'b1;
            m_age[i]  = 0;
            p[i]      = 1'b1;
          end
        end else if (!button_in[i]) begin
          m_down[i] = 1'b0;
          r[i]      = 1'b1;
        end else begin
          m_age[i]++;
          t[i] = (m_age[i] >= HOLD) && ((m_age[i] - HOLD) % REP == 0);
          h[i] = (m_age[i] >= HOLD);
        end
      end
      c    = sw_in ^ m_sw;
      m_sw = sw_in;
      exp_q.delete();
      exp_q.push_back({p, r, t, h, m_sw, c});
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk("press",     {4'h0, btn_press},   {4'h0, e[31:28]});
    chk("release",   {4'h0, btn_release}, {4'h0, e[27:24]});
    chk("repeat",    {4'h0, btn_repeat},  {4'h0, e[23:20]});
    chk("held",      {4'h0, btn_held},    {4'h0, e[19:16]});
    chk("sw_state",  sw_state,            e[15:8]);
    chk("sw_change", sw_change,           e[7:0]);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {btn_press, btn_release}, 8'h00);
    chk(name, {btn_repeat, btn_held}, 8'h00);
    chk(name, sw_state, 8'h00);
    chk(name, sw_change, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #12;
    chk_all_zero("reset_state");
    tick();
    rst_n = 1'b1;
    idle(2);

    // Short press on button 0: press then release, no repeat.
    button_in[0] = 1'b1;
    for (int j = 0; j <= 4; j++) begin
      tick();
      chk("s1_press",   {7'h0, btn_press[0]},   {7'h0, j == 0});
      chk("s1_release", {7'h0, btn_release[0]}, {7'h0, j == 3});
      chk("s1_repeat",  {4'h0, btn_repeat, btn_held[0], 3'h0}, 8'h00);
      if (j == 2) button_in[0] = 1'b0;
    end
    idle(2);

    // Long hold on button 1: repeats at k+8, k+12, k+16, release at k+20.
    button_in[1] = 1'b1;
    for (int j = 0; j <= 21; j++) begin
      tick();
      chk("s2_press",   {7'h0, btn_press[1]},   {7'h0, j == 0});
      chk("s2_repeat",  {7'h0, btn_repeat[1]},  {7'h0, j == 8 || j == 12 || j == 16});
      chk("s2_held",    {7'h0, btn_held[1]},    {7'h0, j >= 8 && j < 20});
      chk("s2_release", {7'h0, btn_release[1]}, {7'h0, j == 20});
      if (j == 19) button_in[1] = 1'b0;
    end
    idle(2);

    // Buttons 2 and 3 together; 2 drops exactly at the hold boundary.
    button_in[3:2] = 2'b11;
    for (int j = 0; j <= 8; j++) begin
      tick();
      if (j == 7) button_in[2] = 1'b0;
    end
    chk("s3_rel2",  {7'h0, btn_release[2]}, 8'h01);
    chk("s3_rep2",  {7'h0, btn_repeat[2]},  8'h00);
    chk("s3_held2", {7'h0, btn_held[2]},    8'h00);
    chk("s3_rep3",  {7'h0, btn_repeat[3]},  8'h01);
    chk("s3_held3", {7'h0, btn_held[3]},    8'h01);
    button_in[3] = 1'b0;
    idle(3);

    // Switch changes.
    sw_in = 8'hA5;
    tick();
    chk("s4_chg_a", sw_change, 8'hA5);
    chk("s4_st_a",  sw_state,  8'hA5);
    tick();
    chk("s4_chg_a0", sw_change, 8'h00);
    sw_in = 8'h24;
    tick();
    chk("s4_chg_b", sw_change, 8'h81);
    chk("s4_st_b",  sw_state,  8'h24);
    tick();
    chk("s4_chg_b0", sw_change, 8'h00);
    sw_in = 8'h00;
    idle(2);

    // Asynchronous reset while button 1 repeats, then restart with it held.
    button_in[1] = 1'b1;
    idle(11);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("s5_async_reset");
    tick();
    rst_n = 1'b1;
    for (int j = 0; j <= 9; j++) begin
      tick();
      chk("s5_press",  {7'h0, btn_press[1]},  {7'h0, j == 0});
      chk("s5_repeat", {7'h0, btn_repeat[1]}, {7'h0, j == 8});
    end
    button_in[1] = 1'b0;
    idle(3);

    // Random phase: slow button toggles so holds reach repeat, random
    // switches, occasional asynchronous reset pulses.
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 15) == 0) button_in[i] = ~button_in[i];
      if ($urandom_range(0, 3) == 0) sw_in = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("rand_reset");
        #2;
        rst_n = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
